// File: rtl/fpu_itof_seq.sv
// -----------------------------------------------------------------------------
// fpu_itof_seq
// Multi-cycle 32-bit integer (signed or unsigned) to IEEE-754 single precision
// converter. Return path of the float-to-integer unit in the FPU conversion
// slice.
//
// Flow: IDLE captures the operand, ABS forms sign and magnitude, NORM shifts
// the magnitude left one bit per cycle until its MSB is set (decrementing the
// biased exponent each shift), ROUND applies round-to-nearest-even, and DONE
// holds the result under a valid/ready handshake.
//
// Ports:
//   Clk_CI       in   clock, rising edge
//   Rst_RBI      in   asynchronous active-low reset
//   Valid_SI     in   operand valid
//   Ready_SO     out  block can accept an operand (IDLE only)
//   Operand_DI   in   integer operand [C_OP]
//   Unsigned_SI  in   1: operand unsigned, 0: two's complement
//   Valid_SO     out  result valid (DONE only)
//   Ready_SI     in   consumer accepts the result
//   Result_DO    out  {sign, exp[C_EXP], frac[C_MANT]}
//   Zero_SO      out  result is +0
//   IX_SO        out  result is inexact
// -----------------------------------------------------------------------------
module fpu_itof_seq #(
  parameter int C_OP   = 32,
  parameter int C_EXP  = 8,
  parameter int C_MANT = 23,
  parameter int C_BIAS = 127
) (
  input  logic            Clk_CI,
  input  logic            Rst_RBI,
  input  logic            Valid_SI,
  output logic            Ready_SO,
  input  logic [C_OP-1:0] Operand_DI,
  input  logic            Unsigned_SI,
  output logic            Valid_SO,
  input  logic            Ready_SI,
  output logic [C_OP-1:0] Result_DO,
  output logic            Zero_SO,
  output logic            IX_SO
);

  // Bit position of the guard bit once the magnitude is normalised (MSB set).
  localparam int LP_GUARD = C_OP - 2 - C_MANT;

  // Exponent of a magnitude whose MSB sits at bit C_OP-1.
  localparam logic [C_EXP-1:0] LP_EXP_INIT = C_EXP'(C_BIAS + C_OP - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ABS   = 3'd1,
    S_NORM  = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Round-to-nearest-even decision from guard, sticky and fraction LSB.
  function automatic logic rne_up(input logic guard, input logic sticky,
                                  input logic lsb);
    rne_up = guard & (sticky | lsb);
  endfunction

  state_t              r_state;
  logic [C_OP-1:0]     r_op;
  logic                r_uns;
  logic                r_sign;
  logic [C_OP-1:0]     r_mag;
  logic [C_EXP-1:0]    r_exp;
  logic                r_ready;
  logic                r_valid;
  logic [C_OP-1:0]     r_result;
  logic                r_zero;
  logic                r_ix;

  logic                w_sign;
  logic [C_OP-1:0]     w_mag;
  logic [C_MANT-1:0]   w_frac;
  logic                w_guard;
  logic                w_sticky;
  logic [C_MANT:0]     w_frac_sum;
  logic [C_MANT-1:0]   w_frac_rnd;
  logic [C_EXP-1:0]    w_exp_rnd;

  // Sign and magnitude of the captured operand (most negative value maps to itself).
  always_comb begin
    w_sign = 1'b0;
    w_mag  = r_op;
    w_sign = ~r_uns & r_op[C_OP-1];
    if (w_sign) begin
      w_mag = ~r_op + C_OP'(1);
    end else begin
      w_mag = r_op;
    end
  end

  // Rounding of the normalised magnitude; a carry out of the fraction bumps the exponent.
  always_comb begin
    w_frac     = r_mag[C_OP-2 -: C_MANT];
    w_guard    = r_mag[LP_GUARD];
    w_sticky   = |r_mag[LP_GUARD-1:0];
    w_frac_sum = {1'b0, w_frac} + {{C_MANT{1'b0}}, rne_up(w_guard, w_sticky, w_frac[0])};
    w_frac_rnd = w_frac_sum[C_MANT-1:0];
    w_exp_rnd  = r_exp;
    if (w_frac_sum[C_MANT]) begin
      w_exp_rnd = r_exp + C_EXP'(1);
    end else begin
      w_exp_rnd = r_exp;
    end
  end

  // Conversion FSM with registered handshake and result outputs.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_uns    <= 1'b0;
      r_sign   <= 1'b0;
      r_mag    <= '0;
      r_exp    <= '0;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_ix     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Valid_SI) begin
            r_op    <= Operand_DI;
            r_uns   <= Unsigned_SI;
            r_ready <= 1'b0;
            r_state <= S_ABS;
          end
        end
        S_ABS: begin
          r_sign <= w_sign;
          r_mag  <= w_mag;
          r_exp  <= LP_EXP_INIT;
          if (w_mag == '0) begin
            r_result <= '0;
            r_zero   <= 1'b1;
            r_ix     <= 1'b0;
            r_valid  <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          if (r_mag[C_OP-1]) begin
            r_state <= S_ROUND;
          end else begin
            r_mag <= {r_mag[C_OP-2:0], 1'b0};
            r_exp <= r_exp - C_EXP'(1);
          end
        end
        S_ROUND: begin
          r_result <= {r_sign, w_exp_rnd, w_frac_rnd};
          r_zero   <= 1'b0;
          r_ix     <= w_guard | w_sticky;
          r_valid  <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          if (Ready_SI) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign Ready_SO  = r_ready;
  assign Valid_SO  = r_valid;
  assign Result_DO = r_result;
  assign Zero_SO   = r_zero;
  assign IX_SO     = r_ix;

endmodule

// File: tb/tb_fpu_itof_seq.sv
// -----------------------------------------------------------------------------
// tb_fpu_itof_seq
// Table of directed vectors, hand-written backpressure and reset sequences,
// and randomized operands checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_fpu_itof_seq;

  logic        clk;
  logic        rst_n;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] operand;
  logic        uns;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result;
  logic        zero_o;
  logic        ix_o;

  int n_vec;
  int n_err;

  fpu_itof_seq dut (
    .Clk_CI      (clk),
    .Rst_RBI     (rst_n),
    .Valid_SI    (valid_i),
    .Ready_SO    (ready_o),
    .Operand_DI  (operand),
    .Unsigned_SI (uns),
    .Valid_SO    (valid_o),
    .Ready_SI    (ready_i),
    .Result_DO   (result),
    .Zero_SO     (zero_o),
    .IX_SO       (ix_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] op;
    logic        uns;
    logic [31:0] res;
    logic        zero;
    logic        ix;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: exact integer -> float with round-half-to-even via remainder arithmetic.
  task automatic model(input logic [31:0] op, input logic u, output logic [31:0] res,
                       output logic z, output logic ix, output int lat);
    logic        s;
    logic [63:0] mag, q, rem, half;
    int          p, sh;
    logic [7:0]  e;
    s = !u && op[31];
    mag = s ? (64'h1_0000_0000 - {32'd0, op}) : {32'd0, op};
    if (mag == 64'd0) begin
      res = 32'd0; z = 1'b1; ix = 1'b0; lat = 1;
    end else begin
      p = 31;
      while (mag[p] == 1'b0) p--;
      lat = (31 - p) + 3;
      rem = 64'd0;
      if (p <= 23) begin
        q = mag << (23 - p);
      end else begin
        sh = p - 23;
        q = mag >> sh;
        rem = mag - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        if (q == (64'd1 << 24)) begin
          q = 64'd1 << 23;
          p++;
        end
      end
      e = 8'(127 + p);
      res = {s, e, q[22:0]};
      z = 1'b0;
      ix = (rem != 64'd0);
    end
  endtask

  // Accept one operand, wait for Valid_SO with a bound, check it; optionally release.
  task automatic run_conv(input string tag, input logic [31:0] op, input logic u,
                          input logic [31:0] e_res, input logic e_z, input logic e_ix,
                          input int e_lat, input bit release_it);
    int cnt;
    cnt = 0;
    check({tag, "_ready_before"}, 64'(ready_o), 64'd1);
    valid_i = 1'b1; operand = op; uns = u;
    @(posedge clk); #1;
    valid_i = 1'b0; operand = 32'hDEAD_BEEF; uns = 1'b0;
    while (!valid_o && cnt < 60) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (!valid_o) begin
      n_vec++; n_err++;
      $display("FAIL %s_timeout: Valid_SO not seen within 60 cycles", tag);
      return;
    end
    check({tag, "_lat"}, 64'(cnt), 64'(e_lat));
    check({tag, "_res"}, 64'(result), 64'(e_res));
    check({tag, "_zero"}, 64'(zero_o), 64'(e_z));
    check({tag, "_ix"}, 64'(ix_o), 64'(e_ix));
    if (release_it) begin
      ready_i = 1'b1;
      @(posedge clk); #1;
      ready_i = 1'b0;
      check({tag, "_valid_drop"}, 64'(valid_o), 64'd0);
      check({tag, "_hold_res"}, 64'(result), 64'(e_res));
    end
  endtask

  vec_t        tbl[10];
  logic [31:0] m_res, held;
  logic        m_z, m_ix, held_z, held_ix;
  int          m_lat;
  logic [31:0] r_op;
  logic        r_u;

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; valid_i = 1'b0; operand = 32'd0; uns = 1'b0; ready_i = 1'b0;

    tbl[0] = '{32'h0000_0001, 1'b0, 32'h3F80_0000, 1'b0, 1'b0, 34};
    tbl[1] = '{32'hFFFF_FFFF, 1'b0, 32'hBF80_0000, 1'b0, 1'b0, 34};
    tbl[2] = '{32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1};
    tbl[3] = '{32'h8000_0000, 1'b0, 32'hCF00_0000, 1'b0, 1'b0, 3};
    tbl[4] = '{32'h7FFF_FFFF, 1'b0, 32'h4F00_0000, 1'b0, 1'b1, 4};
    tbl[5] = '{32'hFFFF_FFFF, 1'b1, 32'h4F80_0000, 1'b0, 1'b1, 3};
    tbl[6] = '{32'd16777217,  1'b0, 32'h4B80_0000, 1'b0, 1'b1, 10};
    tbl[7] = '{32'd16777219,  1'b0, 32'h4B80_0002, 1'b0, 1'b1, 10};
    tbl[8] = '{32'd16777218,  1'b0, 32'h4B80_0001, 1'b0, 1'b0, 10};
    tbl[9] = '{32'h0000_0003, 1'b1, 32'h4040_0000, 1'b0, 1'b0, 33};

    #12;
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_zero", 64'(zero_o), 64'd0);
    check("rst_ix", 64'(ix_o), 64'd0);
    check("rst_ready", 64'(ready_o), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_conv($sformatf("tbl%0d", i), tbl[i].op, tbl[i].uns, tbl[i].res,
               tbl[i].zero, tbl[i].ix, tbl[i].lat, 1'b1);
      check($sformatf("tbl%0d_ready_after", i), 64'(ready_o), 64'd1);
    end

    // Backpressure: result held, new operands ignored while in DONE.
    run_conv("bp", 32'd16777219, 1'b0, 32'h4B80_0002, 1'b0, 1'b1, 10, 1'b0);
    for (int k = 0; k < 5; k++) begin
      valid_i = k[0] ? 1'b0 : 1'b1;
      operand = 32'h0000_0100 + 32'(k);
      uns = 1'b1;
      @(posedge clk); #1;
      check($sformatf("bp%0d_valid", k), 64'(valid_o), 64'd1);
      check($sformatf("bp%0d_ready", k), 64'(ready_o), 64'd0);
      check($sformatf("bp%0d_res", k), 64'(result), 64'h4B80_0002);
      check($sformatf("bp%0d_ix", k), 64'(ix_o), 64'd1);
      check($sformatf("bp%0d_zero", k), 64'(zero_o), 64'd0);
    end
    valid_i = 1'b0; ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    check("bp_release_ready", 64'(ready_o), 64'd1);
    check("bp_release_valid", 64'(valid_o), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("bp_no_ghost_valid", 64'(valid_o), 64'd0);

    // Reset during NORM aborts the conversion.
    valid_i = 1'b1; operand = 32'd1; uns = 1'b0;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(valid_o), 64'd0);
    check("mid_rst_result", 64'(result), 64'd0);
    check("mid_rst_ready", 64'(ready_o), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 64'(ready_o), 64'd1);
    check("post_rst_valid", 64'(valid_o), 64'd0);
    run_conv("post_rst", 32'd3, 1'b0, 32'h4040_0000, 1'b0, 1'b0, 33, 1'b1);

    // Randomized operands with varied leading-zero counts.
    for (int n = 0; n < 150; n++) begin
      r_op = $urandom() >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) r_op = ~r_op;
      r_u = 1'($urandom_range(0, 1));
      model(r_op, r_u, m_res, m_z, m_ix, m_lat);
      run_conv($sformatf("rnd%0d_%08h_u%0d", n, r_op, r_u), r_op, r_u, m_res,
               m_z, m_ix, m_lat, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_itof_seq.md
Name: fpu_itof_seq

Overview:
- Multi-cycle converter from 32-bit integer (signed or unsigned) to IEEE-754 single precision.
- It is the return path for the float-to-integer unit and sits beside it in the FPU conversion slice.
- An FSM takes the magnitude, normalises it one bit per cycle while decrementing a biased exponent, rounds to nearest-even, then holds the result under a valid/ready handshake.

Parameters:
- C_OP, 32: integer operand width and float result width.
- C_EXP, 8: exponent field width.
- C_MANT, 23: stored fraction width (hidden bit excluded).
- C_BIAS, 127: exponent bias.

Ports:
- Clk_CI  in  1  clock; all state updates on the rising edge.
- Rst_RBI  in  1  reset, asynchronous, active-low.
- Valid_SI  in  1  operand valid.
- Ready_SO  out  1  block can accept an operand.
- Operand_DI  in  C_OP  integer operand.
- Unsigned_SI  in  1  1: treat Operand_DI as unsigned; 0: two's complement.
- Valid_SO  out  1  result valid.
- Ready_SI  in  1  consumer accepts the result.
- Result_DO  out  C_OP  float result {sign, exp[C_EXP], frac[C_MANT]}.
- Zero_SO  out  1  result is +0.
- IX_SO  out  1  result is inexact.

Behaviour:
- Reset (async assert, Rst_RBI=0): state IDLE, Valid_SO=0, Result_DO=0, Zero_SO=0, IX_SO=0, all internal registers 0. Ready_SO=1 once in IDLE.
- Reset mid-operation aborts the conversion; no Valid_SO is produced.
- States: IDLE, ABS, NORM, ROUND, DONE. Ready_SO=1 only in IDLE; Valid_SO=1 only in DONE.
- IDLE: on Valid_SI&Ready_SO (edge 0), capture Operand_DI and Unsigned_SI; go to ABS. Valid_SI in any other state is ignored.
- ABS (edge 1):
  - Sign = ~Unsigned & Op[C_OP-1].
  - Mag = Sign ? (~Op+1) : Op, as C_OP-bit unsigned; 0x80000000 stays 0x80000000.
  - Exp = C_BIAS+C_OP-1 (158).
  - If Mag==0: Result=0x00000000, Zero=1, IX=0; go to DONE.
  - Otherwise go to NORM.
- NORM:
  - If Mag[C_OP-1]==1, go to ROUND.
  - Otherwise Mag<<=1 and Exp-=1; stay in NORM.
  - Takes lz+1 cycles, where lz = leading zeros of the magnitude (0..31).
- ROUND:
  - frac = Mag[30:8], G = Mag[7], S = |Mag[6:0].
  - Round up iff G&(S|frac[0]).
  - Carry out of frac: frac=0, Exp+=1.
  - IX = G|S, Zero = 0. Register Result = {Sign, Exp, frac}; go to DONE.
- Latency: DONE is entered at edge 1 for a zero operand and at edge lz+3 for a nonzero operand. Maximum is 34 cycles (operand 1).
- DONE:
  - Result_DO, Zero_SO and IX_SO are stable while Valid_SO=1.
  - On Valid_SO&Ready_SI go to IDLE. No overlap: Ready_SO stays low until the cycle after the handshake.
- Outputs are registered. After the handshake, Result_DO and the flags hold their last value until the next DONE; Valid_SO drops.
- Overflow, underflow and invalid cannot occur for 32-bit inputs, so no such flags exist.

Test Plan:
- Operand 1, signed -> Result 0x3F800000, IX=0, Zero=0, Valid_SO rises 34 cycles after accept. Operand -1 -> 0xBF800000.
- Operand 0 -> Result 0x00000000, Zero=1, IX=0, Valid_SO 1 cycle after accept. Operand 0x80000000 signed -> 0xCF000000, IX=0, lz=0 path.
- Rounding:
  - 0x7FFFFFFF signed -> 0x4F000000, IX=1 (fraction carry bumps the exponent).
  - 0xFFFFFFFF unsigned -> 0x4F800000, IX=1.
  - 0xFFFFFFFF signed -> 0xBF800000, IX=0.
- Ties:
  - 16777217 -> 0x4B800000, IX=1 (tie to even, down).
  - 16777219 -> 0x4B800002, IX=1 (tie to even, up).
  - 16777218 -> 0x4B800001, IX=0.
- Backpressure: hold Ready_SI=0 for 5 cycles in DONE -> Result_DO and flags stable, Ready_SO=0, Valid_SI pulses with other operands ignored. Release -> IDLE next cycle, Ready_SO=1.
- Reset mid-NORM (operand 1, assert Rst_RBI at cycle 10) -> immediately Valid_SO=0, Result_DO=0. After deassert, Ready_SO=1; a new operand 3 converts to 0x40400000.
